// File: rtl/config_pkg.sv
// Shared FPU configuration: result width and the writeback-buffer entry layout.
package config_pkg;

   localparam int unsigned FLEN       = 64;
   localparam int unsigned FPWB_DEPTH = 2;
   localparam int unsigned REG_W      = 5;
   localparam int unsigned FLAG_W     = 5;

   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [FLAG_W-1:0] flags;
      logic [FLEN-1:0]   data;
   } fpwb_entry_t;

   localparam int unsigned ENTRY_W = $bits(fpwb_entry_t);

endpackage

// File: rtl/fpu_wb_fifo2.sv
// Two-entry in-order FIFO holding packed FPU results; flush clears occupancy only.
// FPU_WB_HAZARD_EN additionally exposes every entry's rd for the hazard compare.
module fpu_wb_fifo2
   import config_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic                      i_flush,
   input  logic [ENTRY_W-1:0]        i_entry,
   output logic [ENTRY_W-1:0]        o_head_c,
   output logic [1:0]                o_count,
   output logic [FPWB_DEPTH-1:0]     o_valid_c
`ifdef FPU_WB_HAZARD_EN
   ,
   output logic [FPWB_DEPTH*REG_W-1:0] o_rds_c
`endif
);

   fpwb_entry_t r_mem [FPWB_DEPTH];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;

   // Occupancy and pointers; a simultaneous push/pop leaves the count unchanged.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) r_wr_ptr <= ~r_wr_ptr;
         if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage is never reset; only occupancy defines what is live.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= fpwb_entry_t'(i_entry);
   end

   assign o_head_c = r_mem[r_rd_ptr];
   assign o_count  = r_count;

   always_comb begin
      o_valid_c = '0;
      for (int i = 0; i < int'(FPWB_DEPTH); i++) begin
         o_valid_c[i] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_rd_ptr == 1'(i)));
      end
   end

`ifdef FPU_WB_HAZARD_EN
   always_comb begin
      o_rds_c = '0;
      for (int i = 0; i < int'(FPWB_DEPTH); i++) begin
         o_rds_c[i*REG_W +: REG_W] = r_mem[i].rd;
      end
   end
`endif

endmodule

// File: rtl/fpu_wb_buffer.sv
// FPU writeback buffer: two-entry result FIFO plus sticky fflags accumulation.
// FPU_WB_HAZARD_EN adds rs1/rs2/rs3 inputs and a combinational hazard output.
module fpu_wb_buffer
   import config_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FLEN-1:0]   in_data,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_flags,
   input  logic              flush,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [4:0]        wb_rd,
   output logic [FLEN-1:0]   wb_data,
   output logic [4:0]        fflags,
   input  logic              fflags_wen,
   input  logic [4:0]        fflags_wdata
`ifdef FPU_WB_HAZARD_EN
   ,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [4:0]        rs3,
   output logic              hazard
`endif
);

   fpwb_entry_t              w_in_entry;
   fpwb_entry_t              w_head;
   logic [1:0]               w_count;
   logic [FPWB_DEPTH-1:0]    w_valid;
   logic                     w_push;
   logic                     w_pop;
   logic [4:0]               r_fflags;
`ifdef FPU_WB_HAZARD_EN
   logic [FPWB_DEPTH*REG_W-1:0] w_rds;
`endif

   assign w_in_entry = '{rd: in_rd, flags: in_flags, data: in_data};
   assign in_ready   = (w_count != 2'(FPWB_DEPTH));
   assign wb_valid   = |w_valid;
   assign w_push     = in_valid && in_ready;
   assign w_pop      = wb_valid && wb_ready;
   assign wb_rd      = w_head.rd;
   assign wb_data    = w_head.data;
   assign fflags     = r_fflags;

   fpu_wb_fifo2 u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_flush   (flush),
      .i_entry   (w_in_entry),
      .o_head_c  (w_head),
      .o_count   (w_count),
      .o_valid_c (w_valid)
`ifdef FPU_WB_HAZARD_EN
      ,
      .o_rds_c   (w_rds)
`endif
   );

   // A commit's flags still accrue during flush: the write port already took the data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fflags <= 5'd0;
      end else begin
         r_fflags <= (fflags_wen ? fflags_wdata : r_fflags) | (w_pop ? w_head.flags : 5'd0);
      end
   end

`ifdef FPU_WB_HAZARD_EN
   // The head stays pending through its own pop cycle.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < int'(FPWB_DEPTH); i++) begin
         if (w_valid[i] && ((w_rds[i*REG_W +: REG_W] == rs1) ||
                            (w_rds[i*REG_W +: REG_W] == rs2) ||
                            (w_rds[i*REG_W +: REG_W] == rs3))) begin
            hazard = 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Self-checking bench for fpu_wb_buffer: directed scenarios then random traffic,
// all checked against a queue-based model of the buffer.
module tb_fpu_wb_buffer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [4:0]  in_rd;
   logic [4:0]  in_flags;
   logic        flush;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic [4:0]  fflags;
   logic        fflags_wen;
   logic [4:0]  fflags_wdata;
`ifdef FPU_WB_HAZARD_EN
   logic [4:0]  rs1, rs2, rs3;
   logic        hazard;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [4:0]  fl;
      logic [63:0] d;
   } ent_t;

   ent_t       q[$];
   logic [4:0] m_ff;

   always #5 clk = ~clk;

   fpu_wb_buffer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_rd        (in_rd),
      .in_flags     (in_flags),
      .flush        (flush),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .fflags       (fflags),
      .fflags_wen   (fflags_wen),
      .fflags_wdata (fflags_wdata)
`ifdef FPU_WB_HAZARD_EN
      ,
      .rs1          (rs1),
      .rs2          (rs2),
      .rs3          (rs3),
      .hazard       (hazard)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic [4:0] rd, input logic [63:0] d,
                        input logic [4:0] fl, input logic wr, input logic fls);
      in_valid = iv;
      in_rd    = rd;
      in_data  = d;
      in_flags = fl;
      wb_ready = wr;
      flush    = fls;
   endtask

   // Called at a falling edge: check outputs against the model, then advance one clock.
   task automatic tick();
      bit         push, pop;
      logic [4:0] hf;
      #1;
      check("wb_valid", wb_valid, q.size() != 0);
      check("in_ready", in_ready, q.size() < 2);
      if (q.size() != 0) begin
         check("wb_rd", wb_rd, q[0].rd);
         check("wb_data", wb_data, q[0].d);
      end
      check("fflags", fflags, m_ff);
`ifdef FPU_WB_HAZARD_EN
      begin
         bit hz = 0;
         foreach (q[k]) if (q[k].rd == rs1 || q[k].rd == rs2 || q[k].rd == rs3) hz = 1;
         check("hazard", hazard, hz);
      end
`endif
      push = in_valid && (q.size() < 2);
      pop  = (q.size() != 0) && wb_ready;
      hf   = pop ? q[0].fl : 5'd0;
      m_ff = (fflags_wen ? fflags_wdata : m_ff) | hf;
      if (pop) q.delete(0);
      if (flush) q.delete();
      else if (push) q.push_back('{rd: in_rd, fl: in_flags, d: in_data});
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset_n      = 1'b0;
      fflags_wen   = 1'b0;
      fflags_wdata = 5'd0;
`ifdef FPU_WB_HAZARD_EN
      rs1 = 5'd0; rs2 = 5'd0; rs3 = 5'd0;
`endif
      drive(0, 0, 0, 0, 0, 0);
      m_ff = 5'd0;
      @(negedge clk);
      tick();
      reset_n = 1'b1;
      tick();

      // Basic latency: result visible the cycle after the push, flags the cycle after the pop.
      drive(1, 5'd3, 64'hFFFFFFFF3F800000, 5'h01, 1, 0);
      tick();
      drive(0, 0, 0, 0, 1, 0);
      #1;
      check("lat_valid", wb_valid, 1'b1);
      check("lat_rd", wb_rd, 5'd3);
      check("lat_data", wb_data, 64'hFFFFFFFF3F800000);
      tick();
      check("lat_fflags", fflags, 5'h01);
      tick();

      // Fill with back-pressure, then drain in order.
      drive(1, 5'd1, 64'h1111, 5'h00, 0, 0); tick();
      drive(1, 5'd2, 64'h2222, 5'h00, 0, 0); tick();
      drive(1, 5'd9, 64'h9999, 5'h00, 0, 0);
      #1;
      check("full_in_ready", in_ready, 1'b0);
      check("full_head", wb_rd, 5'd1);
      tick();
      drive(0, 0, 0, 0, 1, 0); tick();
      #1;
      check("drain_in_ready", in_ready, 1'b1);
      check("drain_second", wb_rd, 5'd2);
      tick();
      tick();

      // Back-to-back push/pop streaming.
      for (int i = 0; i < 20; i++) begin
         drive(1, 5'(i), {32'hCAFE0000, 32'(i)}, 5'(i & 31), 1, 0);
         tick();
      end
      drive(0, 0, 0, 0, 1, 0); tick(); tick();

      // Flush with two entries plus concurrent push and pop.
      drive(1, 5'd4, 64'h4444, 5'h08, 0, 0); tick();
      drive(1, 5'd5, 64'h5555, 5'h00, 0, 0); tick();
      drive(1, 5'd6, 64'h6666, 5'h00, 1, 1); tick();
      drive(0, 0, 0, 0, 0, 0);
      #1;
      check("flush_valid", wb_valid, 1'b0);
      check("flush_ready", in_ready, 1'b1);
      check("flush_ff", fflags[3], 1'b1);
      tick();
      // Flush while a push is accepted: the push must be dropped.
      drive(1, 5'd7, 64'h7777, 5'h00, 0, 0); tick();
      drive(1, 5'd8, 64'h8888, 5'h00, 0, 1); tick();
      drive(0, 0, 0, 0, 0, 0); tick();

      // CSR write merged with a commit in the same cycle.
      fflags_wen = 1'b1; fflags_wdata = 5'h10; tick();
      fflags_wen = 1'b0;
      drive(1, 5'd10, 64'hAAAA, 5'h04, 0, 0); tick();
      drive(0, 0, 0, 0, 1, 0);
      fflags_wen = 1'b1; fflags_wdata = 5'h02; tick();
      fflags_wen = 1'b0;
      #1;
      check("csr_merge", fflags, 5'h06);
      tick();

`ifdef FPU_WB_HAZARD_EN
      drive(1, 5'd7, 64'h7, 5'h00, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0);
      rs1 = 5'd1; rs2 = 5'd7; rs3 = 5'd2;
      #1;
      check("hazard_hit", hazard, 1'b1);
      tick();
      wb_ready = 1'b1; tick();
      wb_ready = 1'b0;
      #1;
      check("hazard_clear", hazard, 1'b0);
      tick();
`endif

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0, 5'($urandom), {$urandom, $urandom},
               5'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
         fflags_wen   = $urandom_range(0, 11) == 0;
         fflags_wdata = 5'($urandom);
`ifdef FPU_WB_HAZARD_EN
         rs1 = 5'($urandom); rs2 = 5'($urandom); rs3 = 5'($urandom);
`endif
         tick();
      end
      fflags_wen = 1'b0;

      // Asynchronous reset in the middle of filling.
      drive(1, 5'd12, 64'hC0C0, 5'h1F, 0, 0); tick();
      drive(1, 5'd13, 64'hD0D0, 5'h00, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_valid", wb_valid, 1'b0);
      check("rst_ready", in_ready, 1'b1);
      check("rst_fflags", fflags, 5'h00);
`ifdef FPU_WB_HAZARD_EN
      check("rst_hazard", hazard, 1'b0);
`endif
      q.delete();
      m_ff = 5'd0;
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      reset_n = 1'b1;
      drive(1, 5'd14, 64'hE0E0, 5'h02, 1, 0); tick();
      drive(0, 0, 0, 0, 1, 0); tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
